// File: rtl/display_capture.sv
// Seven-segment scan monitor: settles each multiplexed digit, decodes it
// back to BCD, assembles a frame and publishes its binary value.
module display_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anod,
  input  logic [7:0]  cat,
  output logic [9:0]  numero,
  output logic [15:0] bcd,
  output logic        valid,
  output logic        err,
  output logic        stale
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] SET_C  = CW'(SETTLE);
  localparam logic [TW-1:0] TO_END = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    SCAN,
    CONVERT,
    PUBLISH
  } state_t;

  state_t state;
  state_t state_n;

  logic [3:0]    anod_q;
  logic [6:0]    cat_q;
  logic [10:0]   key;
  logic [10:0]   prev_key;
  logic          same;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          done;
  logic          done_n;
  logic          capture;

  logic          cand;
  logic [3:0]    slot;
  logic [3:0]    nib;
  logic          bad;

  logic [15:0]   digits;
  logic [15:0]   digits_n;
  logic [3:0]    seen;
  logic [3:0]    seen_n;
  logic          ill;
  logic          ill_n;

  logic [15:0]   snap;
  logic          snap_ill;
  logic [13:0]   acc;
  logic [13:0]   acc_n;
  logic [3:0]    dig;
  logic [1:0]    step;
  logic          go_conv;
  logic          go_pub;
  logic          ok_val;

  logic [TW-1:0] tcnt;

  assign key  = {anod_q, cat_q};
  assign same = (key == prev_key);

  // Exactly one low anode selects a digit slot.
  always_comb begin
    cand = 1'b1;
    slot = 4'b0000;
    case (anod_q)
      4'b1110: slot = 4'b0001;
      4'b1101: slot = 4'b0010;
      4'b1011: slot = 4'b0100;
      4'b0111: slot = 4'b1000;
      default: cand = 1'b0;
    endcase
  end

  always_comb begin
    nib = 4'd0;
    bad = 1'b0;
    case (cat_q)
      7'h40: nib = 4'd0;
      7'h79: nib = 4'd1;
      7'h24: nib = 4'd2;
      7'h30: nib = 4'd3;
      7'h19: nib = 4'd4;
      7'h12: nib = 4'd5;
      7'h02: nib = 4'd6;
      7'h78: nib = 4'd7;
      7'h00: nib = 4'd8;
      7'h10: nib = 4'd9;
      7'h7F: nib = 4'd0;
      default: bad = 1'b1;
    endcase
  end

  // done blocks recapture until the sample changes.
  always_comb begin
    cnt_n   = '0;
    capture = 1'b0;
    done_n  = 1'b0;
    if (cand) begin
      if (!same) begin
        cnt_n = {{(CW-1){1'b0}}, 1'b1};
      end else if (cnt == SET_C) begin
        cnt_n = cnt;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      capture = (cnt_n == SET_C) && !(same && done);
      done_n  = capture || (same && done);
    end
  end

  always_comb begin
    digits_n = digits;
    for (int i = 0; i < 4; i++) begin
      if (capture && slot[i]) begin
        digits_n[4*i +: 4] = nib;
      end
    end
  end

  always_comb begin
    if (state == PUBLISH) begin
      seen_n = 4'b0000;
      ill_n  = 1'b0;
    end else begin
      seen_n = seen | (capture ? slot : 4'b0000);
      ill_n  = ill | (capture && bad);
    end
  end

  always_comb begin
    case (step)
      2'd0:    dig = snap[15:12];
      2'd1:    dig = snap[11:8];
      2'd2:    dig = snap[7:4];
      default: dig = snap[3:0];
    endcase
  end

  assign acc_n  = (acc * 14'd10) + {10'd0, dig};
  assign ok_val = (acc_n <= 14'd1023) && !snap_ill;

  always_comb begin
    state_n = state;
    go_conv = 1'b0;
    go_pub  = 1'b0;
    case (state)
      SCAN: begin
        if (&seen_n) begin
          state_n = CONVERT;
          go_conv = 1'b1;
        end
      end
      CONVERT: begin
        if (step == 2'd3) begin
          state_n = PUBLISH;
          go_pub  = 1'b1;
        end
      end
      PUBLISH: state_n = SCAN;
      default: state_n = SCAN;
    endcase
  end

  assign valid = (state == PUBLISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCAN;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      anod_q   <= 4'hF;
      cat_q    <= 7'h7F;
      prev_key <= {4'hF, 7'h7F};
      cnt      <= '0;
      done     <= 1'b0;
      digits   <= '0;
      seen     <= '0;
      ill      <= 1'b0;
    end else begin
      anod_q   <= anod;
      cat_q    <= cat[6:0];
      prev_key <= key;
      cnt      <= cnt_n;
      done     <= done_n;
      digits   <= digits_n;
      seen     <= seen_n;
      ill      <= ill_n;
    end
  end

  // Snapshot uses next-state digits so the frame closes in its capture cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap     <= '0;
      snap_ill <= 1'b0;
      acc      <= '0;
      step     <= '0;
    end else if (go_conv) begin
      snap     <= digits_n;
      snap_ill <= ill_n;
      acc      <= '0;
      step     <= '0;
    end else if (state == CONVERT) begin
      acc      <= acc_n;
      step     <= step + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      numero <= '0;
      bcd    <= '0;
      err    <= 1'b0;
    end else if (go_pub) begin
      bcd <= snap;
      if (ok_val) begin
        numero <= acc_n[9:0];
        err    <= 1'b0;
      end else begin
        err    <= 1'b1;
      end
    end
  end

  // Publish wins over the terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt  <= '0;
      stale <= 1'b0;
    end else if (go_pub) begin
      tcnt  <= '0;
      stale <= 1'b0;
    end else if (tcnt == TO_END) begin
      stale <= 1'b1;
    end else begin
      tcnt  <= tcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_display_capture.sv
// Bench for display_capture: scoreboard of expected published frames,
// popped by a monitor on every valid pulse.
module tb_display_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anod;
  logic [7:0]  cat;
  logic [9:0]  numero;
  logic [15:0] bcd;
  logic        valid;
  logic        err;
  logic        stale;

  typedef struct packed {
    logic [9:0]  n;
    logic [15:0] b;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;
  int          cyc = 0;
  int          last_vcyc = 0;
  logic [9:0]  model_n = '0;
  logic [15:0] model_b = '0;

  always #5 clk = ~clk;

  display_capture #(
    .SETTLE(4),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .anod(anod),
    .cat(cat),
    .numero(numero),
    .bcd(bcd),
    .valid(valid),
    .err(err),
    .stale(stale)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int seg2d(input logic [7:0] c);
    case (c[6:0])
      7'h40: return 0;
      7'h79: return 1;
      7'h24: return 2;
      7'h30: return 3;
      7'h19: return 4;
      7'h12: return 5;
      7'h02: return 6;
      7'h78: return 7;
      7'h00: return 8;
      7'h10: return 9;
      7'h7F: return 0;
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      pulses++;
      last_vcyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        checks += 4;
        if (numero !== mon_e.n) begin
          errors++;
          $display("FAIL sb_numero got=%0d want=%0d", numero, mon_e.n);
        end
        if (bcd !== mon_e.b) begin
          errors++;
          $display("FAIL sb_bcd got=%h want=%h", bcd, mon_e.b);
        end
        if (err !== mon_e.e) begin
          errors++;
          $display("FAIL sb_err got=%b want=%b", err, mon_e.e);
        end
        if (stale !== 1'b0) begin
          errors++;
          $display("FAIL sb_stale got=%b want=0", stale);
        end
      end
    end
  end

  task automatic put(input logic [3:0] a, input logic [7:0] c,
                     input int hold);
    anod = a;
    cat  = c;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] th, input logic [7:0] hu,
                            input logic [7:0] te, input logic [7:0] un);
    int d[4];
    bit bad;
    int v;
    exp_t e;
    bad  = 1'b0;
    d[3] = seg2d(th);
    d[2] = seg2d(hu);
    d[1] = seg2d(te);
    d[0] = seg2d(un);
    for (int i = 0; i < 4; i++) begin
      if (d[i] < 0) begin
        bad  = 1'b1;
        d[i] = 0;
      end
    end
    v = d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
    e.b = {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
    if (v <= 1023 && !bad) begin
      model_n = 10'(v);
      e.e = 1'b0;
    end else begin
      e.e = 1'b1;
    end
    e.n = model_n;
    model_b = e.b;
    sb.push_back(e);
  endtask

  // Units first, thousands last; returns the cycle the last digit was driven.
  task automatic frame(input logic [7:0] th, input logic [7:0] hu,
                       input logic [7:0] te, input logic [7:0] un,
                       input bit expect_it, output int last_drive);
    if (expect_it) push_frame(th, hu, te, un);
    put(4'hF, 8'hFF, 4);
    put(4'b1110, un, 8);
    put(4'b1101, te, 8);
    put(4'b1011, hu, 8);
    last_drive = cyc;
    put(4'b0111, th, 8);
  endtask

  task automatic wait_pulse(input int target, input string name);
    int n;
    n = 0;
    while (pulses < target && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (pulses < target) begin
      errors++;
      $display("FAIL %s_timeout pulses=%0d want=%0d", name, pulses, target);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    anod  = 4'hF;
    cat   = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({numero, bcd, valid, err, stale} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0",
               {numero, bcd, valid, err, stale});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int base;
    int d;
    base = pulses;
    frame(8'hC0, 8'hB0, 8'hF8, 8'h92, 1'b1, d);
    wait_pulse(base + 1, "basic");
    checks++;
    if (last_vcyc - d !== 9) begin
      errors++;
      $display("FAIL basic_latency got=%0d want=9", last_vcyc - d);
    end
    put(4'hF, 8'hFF, 10);
    checks++;
    if (pulses !== base + 1) begin
      errors++;
      $display("FAIL basic_pulse_count got=%0d want=%0d", pulses, base + 1);
    end
    checks++;
    if (numero !== 10'd375 || bcd !== 16'h0375 || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_value got=%0d/%h/%b want=375/0375/0",
               numero, bcd, err);
    end
  endtask

  task automatic test_range;
    int base;
    int d;
    base = pulses;
    frame(8'hF9, 8'hA4, 8'hC0, 8'hC0, 1'b1, d);
    wait_pulse(base + 1, "range");
    checks++;
    if (numero !== 10'd375 || bcd !== 16'h1200 || err !== 1'b1) begin
      errors++;
      $display("FAIL range_value got=%0d/%h/%b want=375/1200/1",
               numero, bcd, err);
    end
  endtask

  task automatic test_glitch;
    int base;
    base = pulses;
    put(4'hF, 8'hFF, 4);
    put(4'b0111, 8'hF9, 8);
    put(4'b1011, 8'hC0, 8);
    put(4'b1110, 8'hB0, 8);
    put(4'b1101, 8'h90, 2);
    put(4'hF, 8'hFF, 14);
    checks++;
    if (pulses !== base) begin
      errors++;
      $display("FAIL glitch_captured pulses=%0d want=%0d", pulses, base);
    end
    push_frame(8'hF9, 8'hC0, 8'hA4, 8'hB0);
    put(4'b1101, 8'hA4, 8);
    wait_pulse(base + 1, "glitch");
    checks++;
    if (numero !== 10'd1023) begin
      errors++;
      $display("FAIL glitch_value got=%0d want=1023", numero);
    end
  endtask

  task automatic test_blank_illegal;
    int base;
    int d;
    base = pulses;
    frame(8'hFF, 8'hFF, 8'hF8, 8'hF8, 1'b1, d);
    wait_pulse(base + 1, "blank");
    checks++;
    if (numero !== 10'd77 || err !== 1'b0) begin
      errors++;
      $display("FAIL blank_value got=%0d/%b want=77/0", numero, err);
    end
    frame(8'hFF, 8'hFF, 8'hAA, 8'hF8, 1'b1, d);
    wait_pulse(base + 2, "illegal");
    checks++;
    if (numero !== 10'd77 || err !== 1'b1 || bcd !== 16'h0007) begin
      errors++;
      $display("FAIL illegal_value got=%0d/%h/%b want=77/0007/1",
               numero, bcd, err);
    end
  endtask

  task automatic test_stale;
    int t0;
    int base;
    int d;
    t0 = last_vcyc;
    anod = 4'hF;
    cat  = 8'hFF;
    while (cyc < t0 + 50) put(4'hF, 8'hFF, 1);
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("FAIL stale_early got=%b want=0", stale);
    end
    while (cyc < t0 + 72) put(4'hF, 8'hFF, 1);
    checks++;
    if (stale !== 1'b1 || numero !== model_n || bcd !== model_b) begin
      errors++;
      $display("FAIL stale_hold got=%b/%0d/%h want=1/%0d/%h",
               stale, numero, bcd, model_n, model_b);
    end
    base = pulses;
    frame(8'hC0, 8'hF9, 8'hA4, 8'h80, 1'b1, d);
    wait_pulse(base + 1, "stale_clear");
    checks++;
    if (stale !== 1'b0 || numero !== 10'd128) begin
      errors++;
      $display("FAIL stale_clear got=%b/%0d want=0/128", stale, numero);
    end
  endtask

  task automatic test_reset_convert;
    int base;
    base = pulses;
    put(4'hF, 8'hFF, 4);
    put(4'b1110, 8'hA4, 8);
    put(4'b1101, 8'h99, 8);
    put(4'b1011, 8'hC0, 8);
    put(4'b0111, 8'hC0, 7);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    anod  = 4'hF;
    cat   = 8'hFF;
    model_n = '0;
    checks++;
    if ({numero, bcd, valid, err, stale} !== 29'd0) begin
      errors++;
      $display("FAIL midreset_outputs got=%h want=0",
               {numero, bcd, valid, err, stale});
    end
    put(4'hF, 8'hFF, 15);
    checks++;
    if (pulses !== base) begin
      errors++;
      $display("FAIL midreset_valid pulses=%0d want=%0d", pulses, base);
    end
    push_frame(8'hC0, 8'hC0, 8'h99, 8'hA4);
    put(4'b1110, 8'hA4, 8);
    put(4'b1101, 8'h99, 8);
    put(4'b1011, 8'hC0, 8);
    put(4'b0111, 8'hC0, 8);
    wait_pulse(base + 1, "midreset");
    checks++;
    if (numero !== 10'd42 || bcd !== 16'h0042) begin
      errors++;
      $display("FAIL midreset_value got=%0d/%h want=42/0042", numero, bcd);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_range();
    test_glitch();
    test_blank_illegal();
    test_stale();
    test_reset_convert();
    put(4'hF, 8'hFF, 5);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_capture.md
Name: display_capture

Overview:
- Receive-side counterpart of the multiplexed 4-digit seven-segment driver: monitors the `anod`/`cat` scan lines and reconstructs the displayed value.
- Decodes each digit's segment pattern back to BCD, assembles a complete frame, and converts it to a 10-bit binary number.
- Used as a self-check/loopback monitor in the display path and as a capture front-end for external panels.

Parameters:
- SETTLE, 4, consecutive identical samples needed to accept a digit (min 1).
- TIMEOUT, 1048576, cycles without a complete frame before `stale` asserts.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- anod  in  4  anode lines, active-low; `anod[0]` = units … `anod[3]` = thousands
- cat  in  8  cathode lines, active-low, `{dp,g,f,e,d,c,b,a}`; dp ignored
- numero  out  10  last published binary value
- bcd  out  16  last published digits `{thousands,hundreds,tens,units}`
- valid  out  1  one-cycle pulse when `numero`/`bcd` update
- err  out  1  last frame had an illegal segment pattern or value >1023
- stale  out  1  no complete frame within TIMEOUT cycles

Behaviour:
- **Clock and reset.** One clock, `clk`. Reset is synchronous and active-high on `reset`.
- **Reset values.** `numero`=0, `bcd`=0, `valid`=0, `err`=0, `stale`=0. The seen-mask, digit registers, settle counter and timeout counter all clear. FSM goes to SCAN.
- **Input stage.**
  - `anod`/`cat` pass through one input register stage; all logic uses the registered copy.
  - A sample is a candidate only if exactly one `anod` bit is 0.
- **Settle.**
  - The settle counter increments while the registered `{anod,cat[6:0]}` equals the previous cycle's value; any change reloads it to 1.
  - When the count reaches SETTLE, the digit is captured once:
    - the decoded nibble is written into the slot selected by `anod`;
    - the matching seen-mask bit is set.
  - Further identical cycles do not recapture.
  - Non-candidate anode patterns (0 or ≥2 low bits) reset the counter and capture nothing.
- **Decode (`cat[6:0]`, active-low).**
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - 7F (blank) → 0.
  - Any other pattern → 0 with the per-frame illegal flag set.
- **FSM states.**
  - **SCAN:** captures digits. When the seen-mask = 1111, the FSM moves to CONVERT and snapshots the digits and the illegal flag.
  - **CONVERT:** 4 cycles. `acc` = `acc`*10 + digit, thousands first; `acc` is 14 bits wide, with no overflow possible (max 9999).
  - **PUBLISH:** 1 cycle.
    - `bcd` ← snapshot.
    - If `acc` ≤ 1023 and no illegal pattern: `numero` ← `acc[9:0]`, `err` ← 0.
    - Otherwise: `numero` holds its old value, `err` ← 1.
    - `valid` = 1 in this cycle.
    - Seen-mask clears and the FSM returns to SCAN.
- **Latency.** `valid` asserts 5 cycles after the cycle in which the fourth distinct digit is captured.
- **Capture during CONVERT/PUBLISH.** Captures continue into the live digit registers but do not alter the snapshot. The seen-mask clear at PUBLISH discards them, so each frame starts fresh.
- **Repeated digit in a frame.** Recapturing a slot before the mask completes overwrites that digit; the latest value wins.
- **Timeout counter.**
  - Counts every cycle and clears on PUBLISH.
  - On reaching TIMEOUT-1, `stale` ← 1 and the counter saturates.
  - `stale` clears at the next PUBLISH.
  - `numero` and `bcd` are retained while stale.
- **Simultaneous events.** If PUBLISH and timeout terminal count coincide, PUBLISH wins (`stale`=0).
- **Reset mid-operation.** Reset in any state aborts the frame. No `valid` is issued; all outputs take their reset values on the next edge.

Test Plan:
1. Scan units=92, tens=F8, hundreds=B0, thousands=C0, each held 8 cycles → after the 4th capture plus 5 cycles: `valid` pulse, `numero`=375, `bcd`=16'h0375, `err`=0.
2. Thousands=F9, hundreds=A4, tens=C0, units=C0 (1200) → `valid` pulse, `bcd`=16'h1200, `err`=1, `numero` keeps 375.
3. Digit held 2 cycles (SETTLE=4) between valid digits → not captured, seen-mask incomplete, no `valid`; then a full 4-digit frame (1023) → `numero`=1023.
4. `cat`=8'hFF (blank) on thousands/hundreds with 7 (F8) and 7 (F8) → `numero`=77; an illegal pattern 8'hAA on tens → `err`=1.
5. TIMEOUT=64, anodes held all-high → `stale`=1 at cycle 64, outputs retained; next valid frame → `stale`=0 with the `valid` pulse.
6. Assert `reset` during CONVERT → no `valid`, `numero`=0, `bcd`=0; a subsequent frame publishes normally.
